// File: rtl/fifo_rd_stream_if.sv
// Bundle between the FIFO read port, the drain stage and the
// downstream valid/ready stream consumer.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 32
);
    logic             fifo_empty;
    logic             fifo_ren;
    logic [WIDTH-1:0] fifo_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       buf_level;
    logic [CNT_W-1:0] word_count;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_ren,
        output m_valid,
        output m_data,
        output buf_level,
        output word_count
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_ren,
        input  m_valid,
        input  m_data,
        input  buf_level,
        input  word_count
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream
// through a 3-entry skid buffer; fifo_ren never looks at m_ready.
module fifo_rd_stream #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               rst,
    fifo_rd_stream_if.master  bus
);
    logic [WIDTH-1:0] mem [3];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [1:0]       count;
    logic             inflight;
    logic [CNT_W-1:0] wcnt;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign push = inflight;
    assign pop  = (count != 2'd0) && bus.m_ready;

    // Issue a read only when a slot is guaranteed for the returning word.
    always_comb begin
        bus.fifo_ren = !bus.fifo_empty && !rst &&
                       (({1'b0, count} + {2'b00, inflight}) < 3'd3);
    end

    // Present the head entry straight from registered storage.
    always_comb begin
        head = mem[0];
        unique case (rd_ptr)
            2'd1:    head = mem[1];
            2'd2:    head = mem[2];
            default: head = mem[0];
        endcase
    end

    assign bus.m_valid    = (count != 2'd0);
    assign bus.m_data     = head;
    assign bus.buf_level  = count;
    assign bus.word_count = wcnt;

    // Skid buffer storage, pointers, occupancy and delivered-word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            mem[2]   <= '0;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 2'd0;
            inflight <= 1'b0;
            wcnt     <= '0;
        end else begin
            inflight <= bus.fifo_ren;
            if (push) begin
                unique case (wr_ptr)
                    2'd1:    mem[1] <= bus.fifo_rdata;
                    2'd2:    mem[2] <= bus.fifo_rdata;
                    default: mem[0] <= bus.fifo_rdata;
                endcase
                wr_ptr <= inc3(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= inc3(rd_ptr);
                wcnt   <= wcnt + CNT_W'(1);
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side drain stage placed directly downstream of the team's async FIFO, in the read clock domain. It drives the FIFO's ren/rdata/empty interface, absorbs the FIFO's one-cycle read latency, and presents the words as a valid/ready stream. It sustains one word per cycle with no combinational path from m_ready to fifo_ren.

Parameters:
WIDTH, 36, data word width; must match the FIFO WIDTH.
CNT_W, 32, width of the delivered-word statistics counter.

Ports:
clk  input  1  read-domain clock; same clock as the FIFO rclk.
rst  input  1  asynchronous reset, active-high.
fifo_empty  input  1  FIFO empty flag.
fifo_ren  output  1  FIFO read enable.
fifo_rdata  input  WIDTH  FIFO read data; valid in the cycle after fifo_ren.
m_valid  output  1  output stream valid.
m_ready  input  1  output stream ready.
m_data  output  WIDTH  output stream data; head of the skid buffer.
buf_level  output  2  skid-buffer occupancy, 0..3.
word_count  output  CNT_W  count of words accepted downstream (m_valid && m_ready).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: fifo_ren=0, m_valid=0, m_data=0, buf_level=0, word_count=0. The internal inflight flag is also 0.
- Internal state:
  - 3-entry circular skid buffer, with rd_ptr, wr_ptr and count, all registered.
  - inflight register = fifo_ren of the previous cycle.
- Read issue:
  - fifo_ren = !fifo_empty && !rst && (count + inflight) < 3.
  - fifo_ren depends only on registers and fifo_empty. It never depends on m_ready.
- Capture: on each rising edge with inflight=1, write fifo_rdata into entry wr_ptr and advance wr_ptr (mod 3).
- Output:
  - m_valid = (count != 0).
  - m_data = entry rd_ptr, registered storage.
  - Pop on m_valid && m_ready: advance rd_ptr (mod 3) and increment word_count. word_count wraps at 2^CNT_W.
- Count update: count += push − pop. Simultaneous push and pop leave count unchanged. A push into a full buffer cannot occur, by construction of the issue rule.
- Latency: fifo_empty falls in cycle t → fifo_ren=1 in t → rdata captured at the end of t+1 → m_valid=1 in t+2. Minimum latency is 2 cycles.
- Throughput: with m_ready held high and the FIFO non-empty, steady state is count=1, inflight=1, and one word per cycle.
- Backpressure:
  - With m_ready low, at most 3 words are fetched.
  - fifo_ren then stays 0 until a pop frees a slot. The first re-issue is the cycle after the pop.
- Stream rules:
  - Once asserted, m_valid stays high and m_data stays stable until the word is accepted.
  - Word order is identical to FIFO order. There is no loss and no duplication.
- Empty handling: fifo_empty=1 blocks issue. A read already issued still completes its capture.
- Reset mid-operation:
  - All state clears immediately. Buffered words and any in-flight word are discarded.
  - The system resets the FIFO read side together with this block.
- buf_level = count.

Test Plan:
- Reset, then load FIFO with 0x1,0x2,0x3, m_ready=1 → fifo_ren high 3 consecutive cycles from the first non-empty cycle. m_data 0x1,0x2,0x3 on consecutive cycles, starting 2 cycles after the first fifo_ren. word_count=3.
- Load 10 words, m_ready=0 → exactly 3 fifo_ren pulses, buf_level=3, m_valid=1, m_data=word0 stable. Raise m_ready → all 10 delivered in order, one per cycle after refill settles. word_count=10.
- FIFO with 5 words, m_ready toggling 1,0,1,0 → no word lost or repeated, and m_data holds while m_valid && !m_ready.
- FIFO runs empty mid-burst (fifo_empty=1 after word 4) → fifo_ren drops the same cycle, word 4 still delivered, then m_valid=0 and buf_level=0.
- Assert rst for 1 cycle with buf_level=2 and inflight=1 → outputs at reset values immediately and the buffer is empty after reset. New data delivers normally.
- Force word_count to 2^CNT_W−1 (CNT_W=4: 15), accept 1 word → word_count=0.
